// File: rtl/spdif_pkg.sv
// spdif_pkg: S/PDIF preamble codes, subframe field layout and the assembler FSM state type.
package spdif_pkg;
  localparam logic [2:0] PRE_B = 3'b001, PRE_M = 3'b010, PRE_W = 3'b100;
  localparam int SAMPLE_MSB = 23, VALIDITY = 24, USER_DATA = 25, CHNL_STATUS = 26, PARITY = 27;
  typedef struct packed {
    logic p;
    logic c;
    logic u;
    logic v;
    logic [23:0] sample;
  } subframe_t;
  typedef enum logic {SYNC_WAIT, COLLECT} state_t;
endpackage

// File: rtl/spdif_cs_collector.sv
// spdif_cs_collector: builds the channel-status block from slot-0 C bits of completed frames.
module spdif_cs_collector #(
  parameter int CS_BITS = 192
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               done_i,
  input  logic               block_i,
  input  logic               c_i,
  output logic [CS_BITS-1:0] cs_o,
  output logic               cs_valid_o
);
  localparam int CW = $clog2(CS_BITS);
  localparam logic [CW-1:0] LAST = CW'(CS_BITS - 1);
  logic [CW-1:0] cnt_q, pos;
  logic lock_q, cap, csv_q;
  logic [CS_BITS-1:0] sr_q, sr_d, cs_q;
  always_comb begin
    pos = block_i ? '0 : cnt_q + 1'b1;
    cap = done_i && (block_i || (lock_q && cnt_q < LAST));
    sr_d = sr_q;
    sr_d[pos] = c_i;
  end
  // Once the last bit lands, the next M frame drops lock until a fresh B arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lock_q <= 1'b0;
      sr_q <= '0;
      cs_q <= '0;
      csv_q <= 1'b0;
    end else begin
      csv_q <= cap && pos == LAST;
      if (cap) begin
        cnt_q <= pos;
        lock_q <= 1'b1;
        sr_q <= sr_d;
        if (pos == LAST) cs_q <= sr_d;
      end else if (done_i && lock_q) begin
        lock_q <= 1'b0;
      end
    end
  end
  assign cs_o = cs_q;
  assign cs_valid_o = csv_q;
endmodule

// File: rtl/spdif_frame_assembler.sv
// spdif_frame_assembler: gathers S/PDIF subframes into CHANNELS-slot frames with parity/sequence checks.
// Define SPDIF_ERR_HOLD_EN to replace an errored sample with that slot's last error-free sample.
module spdif_frame_assembler
  import spdif_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 24,
  parameter int CS_BITS  = 192
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ena_i,
  input  logic [27:0]                package_i,
  input  logic [2:0]                 preamble_i,
  output logic [CHANNELS*DATA_W-1:0] data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       block_start_o,
  output logic [CHANNELS-1:0]        err_o,
  output logic [CS_BITS-1:0]         cs_o,
  output logic                       cs_valid_o,
  output logic                       seq_err_o,
  output logic                       ovf_o
);
  localparam int KW = $clog2(CHANNELS);
  state_t state_q;
  logic [KW-1:0] k_q;
  logic [CHANNELS-1:0][DATA_W-1:0] buf_q, frame_d, data_q;
  logic [CHANNELS-1:0] berr_q, err_d, err_q;
  logic [DATA_W-1:0] smp, smp_out;
  logic is_b, is_m, is_w, bad, st, sf_err, done;
  logic bstart_q, c0_q, valid_q, bs_q, seq_q, ovf_q;
  always_comb begin
    is_b = preamble_i == PRE_B;
    is_m = preamble_i == PRE_M;
    is_w = preamble_i == PRE_W;
    bad = !(is_b || is_m || is_w);
    st = ena_i && !bad && (!is_w || state_q == COLLECT);
    sf_err = (^package_i) | package_i[VALIDITY];
    smp = package_i[SAMPLE_MSB -: DATA_W];
    done = st && is_w && k_q == KW'(CHANNELS - 1);
  end
`ifdef SPDIF_ERR_HOLD_EN
  logic [CHANNELS-1:0][DATA_W-1:0] hold_q;
  logic [KW-1:0] slot;
  assign slot = is_w ? k_q : '0;
  assign smp_out = sf_err ? hold_q[slot] : smp;
  always_ff @(posedge clk_i) begin
    if (rst_i) hold_q <= '0;
    else if (st && !sf_err) hold_q[slot] <= smp;
  end
`else
  assign smp_out = smp;
`endif
  always_comb begin
    frame_d = buf_q;
    frame_d[CHANNELS-1] = smp_out;
    err_d = berr_q;
    err_d[CHANNELS-1] = sf_err;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SYNC_WAIT;
      k_q <= '0;
      buf_q <= '0;
      berr_q <= '0;
      bstart_q <= 1'b0;
      c0_q <= 1'b0;
      seq_q <= 1'b0;
    end else begin
      seq_q <= ena_i && (bad || (state_q == COLLECT && !is_w));
      if (ena_i && bad) begin
        state_q <= SYNC_WAIT;
      end else if (st && !is_w) begin
        state_q <= COLLECT;
        k_q <= KW'(1);
        buf_q[0] <= smp_out;
        berr_q[0] <= sf_err;
        bstart_q <= is_b;
        c0_q <= package_i[CHNL_STATUS];
      end else if (st) begin
        buf_q[k_q] <= smp_out;
        berr_q[k_q] <= sf_err;
        k_q <= k_q + 1'b1;
        if (done) state_q <= SYNC_WAIT;
      end
    end
  end
  // A frame completing under backpressure is dropped; completing during an accept replaces it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q <= '0;
      err_q <= '0;
      bs_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= done && valid_q && !ready_i;
      if (done && (!valid_q || ready_i)) begin
        valid_q <= 1'b1;
        data_q <= frame_d;
        err_q <= err_d;
        bs_q <= bstart_q;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end
  spdif_cs_collector #(.CS_BITS(CS_BITS)) u_cs (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .done_i(done),
    .block_i(bstart_q),
    .c_i(c0_q),
    .cs_o(cs_o),
    .cs_valid_o(cs_valid_o)
  );
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign err_o = err_q;
  assign block_start_o = bs_q;
  assign seq_err_o = seq_q;
  assign ovf_o = ovf_q;
endmodule

// File: doc/spdif_frame_assembler.md
Name: spdif_frame_assembler

Overview:
- Collects decoded S/PDIF subframes (28-bit package + 3-bit preamble code, one per ena_i strobe) into multi-channel audio frames with a valid/ready output.
- Checks parity and subframe sequence, and assembles the 192-bit channel-status block of slot 0.
- Sits between the decoder and the sample FIFO/filter path.
- Generalises the fixed stereo {audio, aux} sample path to N slots, a configurable sample width and block tracking.

Parameters:
- CHANNELS, 2, subframes per frame (2..8); slot 0 starts on B/M, slots 1..CHANNELS-1 on W.
- DATA_W, 24, output sample width (16..24); the 24-bit sample is MSB-aligned and truncated to its top DATA_W bits.
- CS_BITS, 192, channel-status block length in frames.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- ena_i  in  1  subframe strobe; package_i/preamble_i valid this cycle.
- package_i  in  28  [23:0] sample (aux in LSBs), [24] V, [25] U, [26] C, [27] P.
- preamble_i  in  3  PRE_B / PRE_M / PRE_W code.
- data_o  out  CHANNELS*DATA_W  frame; slot 0 in the LSBs.
- valid_o  out  1  frame available.
- ready_i  in  1  consumer accepts when valid_o&&ready_i.
- block_start_o  out  1  frame began with PRE_B; qualified by valid_o.
- err_o  out  CHANNELS  per-slot parity-error or V=1 flag; qualified by valid_o.
- cs_o  out  CS_BITS  last complete channel-status block, slot 0.
- cs_valid_o  out  1  1-cycle pulse when cs_o updates.
- seq_err_o  out  1  1-cycle pulse on a sequence error.
- ovf_o  out  1  1-cycle pulse when a frame is dropped.

Behaviour:
- Reset values: all outputs 0. FSM goes to SYNC_WAIT; slot index, CS counter and CS lock are cleared.
- FSM states: SYNC_WAIT and COLLECT(k).
  - SYNC_WAIT: PRE_W strobes are ignored. PRE_B or PRE_M stores slot 0 and moves to COLLECT(1).
  - COLLECT(k) with PRE_W: store slot k. If k==CHANNELS-1, the frame completes and the FSM returns to SYNC_WAIT; otherwise go to COLLECT(k+1).
  - COLLECT(k) with PRE_B or PRE_M: pulse seq_err_o, discard the partial frame, store this subframe as slot 0, go to COLLECT(1).
  - Any undefined preamble code, in any state: pulse seq_err_o and go to SYNC_WAIT.
- Parity: even parity over package_i[27:0] must be 0; a mismatch sets that slot's err bit. V=1 also sets the err bit.
- Latency: valid_o rises on the cycle after the strobe that completes the frame.
- Output register: data_o, block_start_o and err_o stay stable while valid_o&&!ready_i.
- Completion while valid_o&&!ready_i: the new frame is dropped and ovf_o pulses.
- Completion in the same cycle as an accept: the new frame loads and valid_o stays 1.
- Channel status capture:
  - Capture C of slot 0 only for frames that complete, into bit position cnt.
  - PRE_B frame: set cnt=0 and lock=1.
  - cnt==CS_BITS-1 with lock=1: copy the shift register to cs_o and pulse cs_valid_o one cycle after frame completion. The counter then waits for the next B.
  - PRE_B arriving when cnt<CS_BITS-1: discard the partial block, restart at 0, no pulse.
  - A frame while lock=0 (before the first B): not captured.
  - A PRE_M frame with cnt>=CS_BITS-1: clears lock.
- Reset mid-frame or mid-block discards all partial state. cs_o clears to 0.

Optional Feature:
- Macro SPDIF_ERR_HOLD_EN.
- When defined: a slot with its err bit set outputs that slot's last error-free sample (0 after reset) instead of the received sample; err_o still reports the error.
- When undefined: the received sample is passed through unchanged and only flagged.

Decomposition:
- Package spdif_pkg holds:
  - preamble constants PRE_B=3'b001, PRE_M=3'b010, PRE_W=3'b100;
  - field indices SAMPLE_MSB=23, VALIDITY=24, USER_DATA=25, CHNL_STATUS=26, PARITY=27;
  - typedef subframe_t (28-bit packed struct).
- One sub-module, spdif_cs_collector: counter, lock, shift register, cs_o and cs_valid_o.

Test Plan:
- Stereo: B(0x123456), W(0xABCDEF) with ready_i=1 -> next cycle valid_o=1, data_o=0xABCDEF_123456, block_start_o=1, err_o=0.
- Parity: M with package_i[27] flipped, then W -> err_o=2'b01. With SPDIF_ERR_HOLD_EN, slot 0 repeats the previous good sample.
- Sequence: M, M, W -> one seq_err_o pulse; a single frame is output, built from the second M and the W. W while in SYNC_WAIT -> ignored, no output.
- Backpressure: ready_i=0 across two completed frames -> first frame held, ovf_o pulses once; ready_i=1 -> first frame accepted.
- Channel status: 192 frames starting with B, slot 0 C pattern 0xA5 repeating -> cs_valid_o pulses once, cs_o matches. A B after 100 frames -> no pulse.
- CHANNELS=4, DATA_W=16: M, W, W, W with samples 0x111100..0x444400 -> data_o=0x4444_3333_2222_1111; rst_i mid-frame -> no output.
